fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a single-entry
// buffer towards decode, redirect/halt handling and fetch address checking.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_err_i,
   input  logic        e_redirect_i,
   input  logic [31:0] e_target_i,
   input  logic        halt_i,
   input  logic        d_ready_i,
   output logic [31:0] F_pc_o,
   output logic [31:0] f_instr_o,
   output logic        f_valid_o,
   output logic        f_imem_error_o,
   output logic        f_halted_o,
   output logic [31:0] f_fetch_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DROP = 3'd4,
      S_HALT = 3'd5
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic        halt_pend_q;
   logic        outst_q;
   logic        req_q;
   logic        valid_q;
   logic        err_q;
   logic        halted_q;
   logic [31:0] instr_q;
   logic [31:0] fpc_q;
   logic [31:0] cnt_q;

   logic [31:0] npc_s;
   logic        launch_s;
   logic        drop_s;

   // Fetchable window is 0x8000_0000..0x87FF_FFFF, word aligned
   function automatic logic pc_bad(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc[31:27] != 5'b10000);
   endfunction

   // Decide whether this cycle starts a new fetch at npc_s or parks in DROP
   always_comb begin
      npc_s    = pc_q;
      launch_s = 1'b0;
      drop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            npc_s = e_redirect_i ? e_target_i : pc_q;
            if (outst_q && !imem_rvalid_i) begin
               drop_s = 1'b1;
            end else begin
               launch_s = 1'b1;
            end
         end
         S_REQ, S_WAIT, S_DROP: begin
            if (e_redirect_i) begin
               npc_s = e_target_i;
               // A response is still owed if REQ was granted or WAIT/DROP saw no rvalid
               if ((state_q == S_REQ) ? imem_gnt_i : !imem_rvalid_i) begin
                  drop_s = 1'b1;
               end else begin
                  launch_s = 1'b1;
               end
            end else begin
               launch_s = (state_q == S_DROP) && imem_rvalid_i;
            end
         end
         S_HOLD: begin
            if (e_redirect_i) begin
               npc_s    = e_target_i;
               launch_s = 1'b1;
            end else if (d_ready_i && !halt_i && !halt_pend_q) begin
               npc_s    = pc_q + 32'd4;
               launch_s = 1'b1;
            end else begin
               launch_s = 1'b0;
            end
         end
         default: begin
            npc_s = pc_q;
         end
      endcase
   end

   // Main FSM with registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         halt_pend_q <= 1'b0;
         req_q       <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         halted_q    <= 1'b0;
         instr_q     <= 32'h0;
         fpc_q       <= 32'h0;
         cnt_q       <= 32'h0;
      end else begin
         if ((state_q == S_HOLD) && !e_redirect_i && d_ready_i) begin
            cnt_q <= cnt_q + 32'd1;
         end
         if (launch_s) begin
            pc_q <= npc_s;
            if (pc_bad(npc_s)) begin
               state_q <= S_HOLD;
               req_q   <= 1'b0;
               valid_q <= 1'b1;
               err_q   <= 1'b1;
               instr_q <= NOP_INSTR;
               fpc_q   <= npc_s;
            end else begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
               valid_q <= 1'b0;
            end
         end else if (drop_s) begin
            pc_q    <= npc_s;
            state_q <= S_DROP;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_REQ: begin
                  if (imem_gnt_i) begin
                     state_q     <= S_WAIT;
                     req_q       <= 1'b0;
                     halt_pend_q <= halt_pend_q | halt_i;
                  end else if (halt_i) begin
                     state_q  <= S_HALT;
                     req_q    <= 1'b0;
                     halted_q <= 1'b1;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid_i) begin
                     state_q <= S_HOLD;
                     valid_q <= 1'b1;
                     fpc_q   <= pc_q;
                     err_q   <= imem_err_i;
                     instr_q <= imem_err_i ? NOP_INSTR : imem_rdata_i;
                  end
                  if (halt_i) begin
                     halt_pend_q <= 1'b1;
                  end
               end
               S_HOLD: begin
                  // Only a halting consumption reaches here; a normal one launches
                  if (d_ready_i) begin
                     state_q  <= S_HALT;
                     valid_q  <= 1'b0;
                     halted_q <= 1'b1;
                  end
               end
               S_IDLE, S_DROP, S_HALT: begin
               end
               default: begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Granted request still awaiting its response; kept across reset so a
   // response to a request issued before reset is recognised and dropped
   always_ff @(posedge clk_i) begin
      if (req_q && imem_gnt_i) begin
         outst_q <= 1'b1;
      end else if (imem_rvalid_i) begin
         outst_q <= 1'b0;
      end else begin
         outst_q <= outst_q;
      end
   end

   assign imem_req_o     = req_q;
   assign imem_addr_o    = pc_q;
   assign F_pc_o         = fpc_q;
   assign f_instr_o      = instr_q;
   assign f_valid_o      = valid_q;
   assign f_imem_error_o = err_q;
   assign f_halted_o     = halted_q;
   assign f_fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl: transaction-level reference model plus a
// directed prologue with hand-computed expectations.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, gnt, rvalid, err, redir, halt, dready;
   logic [31:0] addr, rdata, target;
   logic [31:0] fpc, finstr, fcnt;
   logic        fvalid, ferr, fhalted;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(err),
      .e_redirect_i(redir), .e_target_i(target), .halt_i(halt), .d_ready_i(dready),
      .F_pc_o(fpc), .f_instr_o(finstr), .f_valid_o(fvalid),
      .f_imem_error_o(ferr), .f_halted_o(fhalted), .f_fetch_cnt_o(fcnt)
   );

   int checks = 0;
   int errors = 0;

   // reference model: fetch address, decode buffer, and transaction flags
   logic [31:0] m_pc, m_bpc, m_binstr, m_cnt;
   bit m_bvalid, m_berr, m_halted, m_req, m_inflight, m_discard, m_pend, m_idle;

   // environment: memory response countdown (0 = nothing owed)
   int mem_cd = 0;

   int k_gnt_pct, k_lat_min, k_lat_max, k_redir_pm, k_halt_pm, k_ready_pct, k_err_pct;
   bit f_redir = 1'b0, f_halt = 1'b0, use_fixed = 1'b0;
   logic [31:0] f_target, fixed_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 32'd4 != 32'd0) || (a < 32'h8000_0000) || (a > 32'h87FF_FFFF);
   endfunction

   task automatic model_reset();
      m_pc = 32'h8000_0000; m_bpc = 32'h0; m_binstr = 32'h0; m_cnt = 32'h0;
      m_bvalid = 0; m_berr = 0; m_halted = 0; m_req = 0;
      m_inflight = 0; m_discard = 0; m_pend = 0; m_idle = 1;
   endtask

   task automatic model_start(input logic [31:0] a);
      m_pc = a;
      if (addr_bad(a)) begin
         m_req = 0; m_bvalid = 1; m_berr = 1; m_binstr = NOP; m_bpc = a;
      end else begin
         m_req = 1; m_bvalid = 0;
      end
   endtask

   task automatic model_step(input bit owed);
      if (m_halted) return;
      if (m_idle) begin
         logic [31:0] a;
         a = redir ? target : m_pc;
         m_idle = 0;
         if (owed) begin
            m_pc = a; m_discard = 1;
         end else model_start(a);
      end else if (m_bvalid) begin
         if (redir) model_start(target);
         else if (dready) begin
            m_cnt = m_cnt + 32'd1;
            if (halt || m_pend) begin
               m_halted = 1; m_bvalid = 0;
            end else model_start(m_pc + 32'd4);
         end
      end else if (m_discard) begin
         if (redir) begin
            m_pc = target;
            if (rvalid) begin m_discard = 0; model_start(target); end
         end else if (rvalid) begin
            m_discard = 0; model_start(m_pc);
         end
      end else if (m_req) begin
         if (redir) begin
            if (gnt) begin m_pc = target; m_req = 0; m_discard = 1; end
            else model_start(target);
         end else if (gnt) begin
            m_req = 0; m_inflight = 1;
            if (halt) m_pend = 1;
         end else if (halt) begin
            m_req = 0; m_halted = 1;
         end
      end else if (m_inflight) begin
         if (redir) begin
            m_inflight = 0;
            if (rvalid) model_start(target);
            else begin m_pc = target; m_discard = 1; end
         end else begin
            if (rvalid) begin
               m_inflight = 0; m_bvalid = 1; m_bpc = m_pc; m_berr = err;
               m_binstr = err ? NOP : rdata;
            end
            if (halt) m_pend = 1;
         end
      end
   endtask

   task automatic compare_model();
      check("req", {31'b0, req}, {31'b0, m_req});
      check("addr", addr, m_pc);
      check("valid", {31'b0, fvalid}, {31'b0, m_bvalid});
      check("halted", {31'b0, fhalted}, {31'b0, m_halted});
      check("cnt", fcnt, m_cnt);
      check("F_pc", fpc, m_bpc);
      check("instr", finstr, m_binstr);
      check("imem_err", {31'b0, ferr}, {31'b0, m_berr});
   endtask

   function automatic logic [31:0] rand_target();
      int unsigned r;
      r = $urandom_range(9);
      if (r < 7) return 32'h8000_0000 + 32'($urandom_range(255)) * 32'd4;
      else if (r == 7) return 32'h8000_0000 + 32'($urandom_range(1023)) * 32'd4 + 32'd2;
      else if (r == 8) return 32'($urandom);
      else return ($urandom_range(1) == 0) ? 32'h87FF_FFF8 : 32'hFFFF_FFFC;
   endfunction

   task automatic step();
      bit owed;
      rvalid = 0; err = 0; rdata = 32'h0;
      if (mem_cd > 0) begin
         mem_cd--;
         if (mem_cd == 0) begin
            rvalid = 1;
            err    = ($urandom_range(99) < k_err_pct);
            rdata  = use_fixed ? fixed_rdata : 32'($urandom);
         end
      end
      owed = (mem_cd > 0);
      gnt = req && (mem_cd == 0) && ($urandom_range(99) < k_gnt_pct);
      if (gnt) mem_cd = $urandom_range(k_lat_max, k_lat_min);
      redir  = f_redir || ($urandom_range(999) < k_redir_pm);
      target = f_redir ? f_target : rand_target();
      halt   = f_halt || ($urandom_range(999) < k_halt_pm);
      dready = ($urandom_range(99) < k_ready_pct);
      f_redir = 0; f_halt = 0;
      model_step(owed);
      @(posedge clk); #1;
      compare_model();
   endtask

   // asynchronous reset mid-cycle; outputs must drop immediately
   task automatic do_reset(input bit lit);
      rst_n = 0; gnt = 0; rvalid = 0; redir = 0; halt = 0;
      #1;
      model_reset();
      compare_model();
      if (lit) begin
         check("rst_req", {31'b0, req}, 32'd0);
         check("rst_valid", {31'b0, fvalid}, 32'd0);
         check("rst_cnt", fcnt, 32'd0);
         check("rst_halted", {31'b0, fhalted}, 32'd0);
         check("rst_instr", finstr, 32'd0);
         check("rst_fpc", fpc, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      f_redir = 1; f_target = t;
      step();
   endtask

   initial begin
      rst_n = 0; gnt = 0; rvalid = 1; err = 0; rdata = 32'h0;
      redir = 0; target = 32'h0; halt = 0; dready = 0;
      @(posedge clk); #1;
      rvalid = 0;

      k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1; k_redir_pm = 0; k_halt_pm = 0;
      k_ready_pct = 100; k_err_pct = 0; use_fixed = 1; fixed_rdata = 32'h0050_0093;
      do_reset(1);

      // basic fetch, immediate grant, 1-cycle response
      step();
      check("first_req", {31'b0, req}, 32'd1);
      check("first_addr", addr, 32'h8000_0000);
      step(); step();
      check("deliver_valid", {31'b0, fvalid}, 32'd1);
      check("deliver_pc", fpc, 32'h8000_0000);
      check("deliver_instr", finstr, 32'h0050_0093);
      step();
      check("next_addr", addr, 32'h8000_0004);
      check("cnt_one", fcnt, 32'd1);

      // decode stall holds the buffer
      k_ready_pct = 0;
      step(); step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", {31'b0, fvalid}, 32'd1);
         check("stall_req", {31'b0, req}, 32'd0);
         check("stall_cnt", fcnt, 32'd1);
         check("stall_pc", fpc, 32'h8000_0004);
      end
      k_ready_pct = 100;
      step();
      check("cnt_two", fcnt, 32'd2);

      // redirect while waiting; stale response 3 cycles after grant
      k_lat_min = 3; k_lat_max = 3;
      step();
      k_lat_min = 1; k_lat_max = 1;
      redirect_to(32'h8000_0100);
      check("drop_req", {31'b0, req}, 32'd0);
      step(); step();
      check("post_drop_req", {31'b0, req}, 32'd1);
      check("post_drop_addr", addr, 32'h8000_0100);
      check("post_drop_valid", {31'b0, fvalid}, 32'd0);
      step(); step();
      check("redir_pc", fpc, 32'h8000_0100);

      // misaligned and out-of-range targets
      redirect_to(32'h8000_0102);
      check("mis_err", {31'b0, ferr}, 32'd1);
      check("mis_instr", finstr, NOP);
      check("mis_req", {31'b0, req}, 32'd0);
      redirect_to(32'h9000_0000);
      check("oor_valid", {31'b0, fvalid}, 32'd1);
      check("oor_pc", fpc, 32'h9000_0000);
      check("oor_cnt", fcnt, 32'd2);

      // halt recorded in WAIT takes effect after delivery
      redirect_to(32'h8000_0200);
      k_lat_min = 2; k_lat_max = 2;
      step();
      f_halt = 1;
      step();
      step();
      check("halt_deliver", fpc, 32'h8000_0200);
      step();
      check("halted", {31'b0, fhalted}, 32'd1);
      check("halt_cnt", fcnt, 32'd3);
      for (int i = 0; i < 3; i++) begin
         step();
         check("halt_noreq", {31'b0, req}, 32'd0);
      end

      // reset in WAIT: the late response must be dropped
      do_reset(1);
      k_lat_min = 3; k_lat_max = 3;
      step(); step();
      k_lat_min = 1; k_lat_max = 1;
      do_reset(1);
      step();
      check("rst_drop_req", {31'b0, req}, 32'd0);
      step(); step();
      check("rst_refetch_addr", addr, 32'h8000_0000);
      check("rst_refetch_req", {31'b0, req}, 32'd1);

      // randomised episodes
      use_fixed = 0;
      for (int ep = 0; ep < 30; ep++) begin
         do_reset(0);
         k_gnt_pct   = $urandom_range(100, 30);
         k_lat_min   = 1;
         k_lat_max   = $urandom_range(4, 1);
         k_redir_pm  = $urandom_range(150);
         k_halt_pm   = $urandom_range(5);
         k_ready_pct = $urandom_range(100, 20);
         k_err_pct   = $urandom_range(20);
         for (int c = 0; c < 600; c++) begin
            if ($urandom_range(999) == 0) do_reset(0);
            else step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
